jd_sweep_ctrl: RTL and testbench
================================

Name: jd_sweep_ctrl

Overview:
Sequencer on the cyclk domain that drives the delay/phase code consumed by the c0-domain delayed-clock generator. It steps a delay code from a start value to a stop value with a programmable step and dwell. Each new code is handed to the generator through a load/ack handshake, and the sweep is held off whenever the PLL is not locked. The block supports single-shot, continuous (wrap) and triangle (ping-pong) sweeps, and is controlled by the top-level measurement FSM through start/abort/busy/done.

Parameters:
CW, 8, delay code width (matches generator compare width)
DW, 16, dwell counter width
ACK_TO, 64, cyclk cycles allowed for code_ack before error; >= 4

Ports:
cyclk  input  1  sweep clock; all logic on rising edge
rst  input  1  reset, synchronous, active-low
locked  input  1  PLL lock, asynchronous; 2-flop synchronised internally
start  input  1  one-cycle pulse; begins sweep when idle
abort  input  1  one-cycle pulse; stops sweep immediately
mode  input  2  00 single, 01 continuous wrap, 10 triangle, 11 = single
start_code  input  CW  first code of sweep
stop_code  input  CW  last code of sweep
step  input  CW  code increment magnitude; 0 treated as 1
dwell  input  DW  cyclk cycles to hold each code after ack; 0 treated as 1
delay_code  output  CW  code presented to generator; stable while code_load high
code_load  output  1  level request; high until code_ack seen
code_ack  input  1  generator acknowledge (already synchronised into cyclk)
busy  output  1  high from accepted start until IDLE
done  output  1  one-cycle pulse at normal completion of single sweep
err  output  1  sticky; set on ack timeout, cleared by next accepted start
point_cnt  output  CW  number of codes acknowledged in current pass

Behaviour:
- Reset (rst=0 at edge): state IDLE; delay_code=0, code_load=0, busy=0, done=0, err=0, point_cnt=0; lock synchroniser cleared to 0.
- Inputs start_code/stop_code/step/dwell/mode are sampled into shadow registers on accepted start; later changes are ignored until the next start.
- Direction: up if start_code <= stop_code, else down. start_code == stop_code gives a one-point sweep.
- States:
  - IDLE: start=1 -> WAIT_LOCK, busy=1, err=0, point_cnt=0, cur=start_code.
  - WAIT_LOCK: stay while synchronised lock=0; else -> LOAD.
  - LOAD: delay_code<=cur, code_load<=1, timeout counter<=0 -> WAIT_ACK.
  - WAIT_ACK: code_ack=1 -> code_load<=0, point_cnt+1, dwell counter<=dwell -> DWELL. If the counter reaches ACK_TO -> err<=1, code_load<=0 -> IDLE; no done pulse.
  - DWELL: decrement each cycle; at 1 -> STEP.
  - STEP: if cur==stop_code, this is the end of the pass; else cur <= cur ± step, clamped to stop_code if it would pass stop_code or wrap beyond the CW range, then -> WAIT_LOCK.
- End of pass:
  - single: done=1 for one cycle -> IDLE.
  - continuous: cur=start_code, point_cnt=0 -> WAIT_LOCK.
  - triangle: swap the working start/stop, invert direction, point_cnt=0 -> WAIT_LOCK; the turnaround code is not repeated, so the next code is stop ∓ step (clamped).
- Minimum latency from start to code_load is 3 cycles with lock already high (2 synchroniser stages are pre-filled, so WAIT_LOCK passes in 1 cycle).
- Lock loss:
  - Sampled in WAIT_ACK or DWELL: drop code_load, -> WAIT_LOCK, then re-present the same cur.
  - point_cnt is not incremented for the abandoned point.
- abort: highest priority in any non-IDLE state; next cycle IDLE, code_load=0, busy=0, no done, delay_code holds its last value. start together with abort in IDLE: abort wins.
- start while busy: ignored.
- rst=0 mid-sweep: full reset values on that edge regardless of code_ack.
- done and err are never asserted in the same cycle.

Test Plan:
- Single up, locked=1: start 10, stop 40, step 10, dwell 3, ack 2 cycles after load -> codes 10,20,30,40 loaded; point_cnt=4; one done pulse; busy falls the same cycle.
- Clamp/down: start 250, stop 5, step 100 -> codes 250,150,50,5; no wrap through 255/0; done.
- Triangle: start 0, stop 3, step 1 -> sequence 0,1,2,3,2,1,0,1,…; no duplicate at the turnarounds; abort -> IDLE next cycle, no done, delay_code holds.
- Lock drop: locked low during DWELL of code 20 -> code_load low, wait; after relock plus 2 sync cycles, code 20 reloaded; point_cnt counts 20 once.
- Ack timeout: code_ack held 0 -> after ACK_TO cycles err=1, busy=0, no done; next start clears err.
- Edge cases:
  - step=0, dwell=0 -> behaves as step 1, dwell 1.
  - start==stop -> one point, then done.
  - rst low mid-WAIT_ACK -> all outputs return to reset values.

Source files
------------

// File: rtl/jd_sweep_ctrl_if.sv
// Code handshake between the sweep sequencer (master) and the delayed-clock
// generator (slave): presented code, level load request and acknowledge.
interface jd_sweep_ctrl_if #(
   parameter int unsigned CW = 8
);
   logic [CW-1:0] delay_code;
   logic          code_load;
   logic          code_ack;

   modport master (output delay_code, output code_load, input code_ack);
   modport slave  (input delay_code, input code_load, output code_ack);
endinterface

// File: rtl/jd_sweep_ctrl.sv
// Delay-code sweep sequencer: steps a code from start to stop with dwell,
// handing each code to the generator via load/ack, gated by PLL lock.
module jd_sweep_ctrl #(
   parameter int unsigned CW     = 8,
   parameter int unsigned DW     = 16,
   parameter int unsigned ACK_TO = 64
) (
   input  logic                  cyclk,
   input  logic                  rst,
   input  logic                  locked,
   input  logic                  start,
   input  logic                  abort,
   input  logic [1:0]            mode,
   input  logic [CW-1:0]         start_code,
   input  logic [CW-1:0]         stop_code,
   input  logic [CW-1:0]         step,
   input  logic [DW-1:0]         dwell,
   jd_sweep_ctrl_if.master       gen,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [CW-1:0]         point_cnt
);

   localparam int unsigned TW = $clog2(ACK_TO + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_LOCK,
      S_LOAD,
      S_WAIT_ACK,
      S_DWELL,
      S_STEP
   } state_t;

   state_t        state_q, state_d;
   logic          lock_s1_q, lock_s2_q;
   logic [CW-1:0] cur_q, cur_d;
   logic [CW-1:0] first_q, first_d;
   logic [CW-1:0] last_q, last_d;
   logic [CW-1:0] step_q, step_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    mode_q, mode_d;
   logic          up_q, up_d;
   logic [CW-1:0] code_q, code_d;
   logic          load_q, load_d;
   logic [CW-1:0] pcnt_q, pcnt_d;
   logic [TW-1:0] to_q, to_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   // Next code toward tgt; clamps to tgt when the step would reach or pass it,
   // which also rules out wrapping through the ends of the code range.
   function automatic logic [CW-1:0] next_code(input logic [CW-1:0] c,
                                               input logic [CW-1:0] tgt,
                                               input logic          up,
                                               input logic [CW-1:0] stp);
      logic [CW-1:0] rem;
      rem = up ? (tgt - c) : (c - tgt);
      if (stp >= rem) return tgt;
      return up ? (c + stp) : (c - stp);
   endfunction

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      first_d = first_q;
      last_d  = last_q;
      step_d  = step_q;
      dwell_d = dwell_q;
      mode_d  = mode_q;
      up_d    = up_q;
      code_d  = code_q;
      load_d  = load_q;
      pcnt_d  = pcnt_q;
      to_d    = to_q;
      dcnt_d  = dcnt_q;
      done_d  = 1'b0;
      err_d   = err_q;

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         load_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  first_d = start_code;
                  last_d  = stop_code;
                  step_d  = (step == '0) ? CW'(1) : step;
                  dwell_d = (dwell == '0) ? DW'(1) : dwell;
                  mode_d  = mode;
                  up_d    = (start_code <= stop_code);
                  cur_d   = start_code;
                  pcnt_d  = '0;
                  err_d   = 1'b0;
                  state_d = S_WAIT_LOCK;
               end
            end
            S_WAIT_LOCK: begin
               if (lock_s2_q) state_d = S_LOAD;
            end
            S_LOAD: begin
               code_d  = cur_q;
               load_d  = 1'b1;
               to_d    = '0;
               state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (!lock_s2_q) begin
                  load_d  = 1'b0;
                  state_d = S_WAIT_LOCK;
               end else if (gen.code_ack) begin
                  load_d  = 1'b0;
                  pcnt_d  = pcnt_q + 1'b1;
                  dcnt_d  = dwell_q;
                  state_d = S_DWELL;
               end else if (to_q == TW'(ACK_TO - 1)) begin
                  err_d   = 1'b1;
                  load_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
            S_DWELL: begin
               // The point was counted on ack; losing lock abandons it, so uncount.
               if (!lock_s2_q) begin
                  pcnt_d  = pcnt_q - 1'b1;
                  state_d = S_WAIT_LOCK;
               end else if (dcnt_q == DW'(1)) begin
                  state_d = S_STEP;
               end else begin
                  dcnt_d = dcnt_q - 1'b1;
               end
            end
            S_STEP: begin
               state_d = S_WAIT_LOCK;
               if (cur_q == last_q) begin
                  if (mode_q == 2'b01) begin
                     cur_d  = first_q;
                     pcnt_d = '0;
                  end else if (mode_q == 2'b10) begin
                     first_d = last_q;
                     last_d  = first_q;
                     up_d    = !up_q;
                     cur_d   = next_code(cur_q, first_q, !up_q, step_q);
                     pcnt_d  = '0;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  cur_d = next_code(cur_q, last_q, up_q, step_q);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge cyclk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         lock_s1_q <= 1'b0;
         lock_s2_q <= 1'b0;
         cur_q     <= '0;
         first_q   <= '0;
         last_q    <= '0;
         step_q    <= '0;
         dwell_q   <= '0;
         mode_q    <= '0;
         up_q      <= 1'b0;
         code_q    <= '0;
         load_q    <= 1'b0;
         pcnt_q    <= '0;
         to_q      <= '0;
         dcnt_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_s1_q <= locked;
         lock_s2_q <= lock_s1_q;
         cur_q     <= cur_d;
         first_q   <= first_d;
         last_q    <= last_d;
         step_q    <= step_d;
         dwell_q   <= dwell_d;
         mode_q    <= mode_d;
         up_q      <= up_d;
         code_q    <= code_d;
         load_q    <= load_d;
         pcnt_q    <= pcnt_d;
         to_q      <= to_d;
         dcnt_q    <= dcnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign gen.delay_code = code_q;
   assign gen.code_load  = load_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = done_q;
   assign err            = err_q;
   assign point_cnt      = pcnt_q;

endmodule

// File: tb/tb_jd_sweep_ctrl.sv
// Directed bench for jd_sweep_ctrl: generator ack responder, load-code log,
// and hand-computed code sequences for each sweep scenario.
module tb_jd_sweep_ctrl;

   localparam int unsigned CW     = 8;
   localparam int unsigned DW     = 16;
   localparam int unsigned ACK_TO = 64;

   logic          cyclk = 1'b0;
   logic          rst = 1'b0;
   logic          locked = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [1:0]    mode = '0;
   logic [CW-1:0] start_code = '0;
   logic [CW-1:0] stop_code = '0;
   logic [CW-1:0] step = '0;
   logic [DW-1:0] dwell = '0;
   logic          busy, done, err;
   logic [CW-1:0] point_cnt;

   jd_sweep_ctrl_if #(.CW(CW)) gen_if ();

   jd_sweep_ctrl #(.CW(CW), .DW(DW), .ACK_TO(ACK_TO)) dut (
      .cyclk      (cyclk),
      .rst        (rst),
      .locked     (locked),
      .start      (start),
      .abort      (abort),
      .mode       (mode),
      .start_code (start_code),
      .stop_code  (stop_code),
      .step       (step),
      .dwell      (dwell),
      .gen        (gen_if),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .point_cnt  (point_cnt)
   );

   always #5 cyclk = ~cyclk;

   int            n_checks = 0;
   int            n_fail = 0;
   bit            ack_en = 1'b1;
   int            ack_dly = 2;
   logic [CW-1:0] load_log[$];
   int            done_cnt = 0;
   int            overlap_cnt = 0;
   int            exp_done = 0;

   // Generator model: acks each load request after ack_dly low-phase samples.
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      gen_if.code_ack = 1'b0;
      forever begin
         @(negedge cyclk);
         if (gen_if.code_ack) begin
            gen_if.code_ack = 1'b0;
         end else if (ack_en && gen_if.code_load) begin
            if (wait_cnt == ack_dly) begin
               gen_if.code_ack = 1'b1;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      logic prev_load;
      prev_load = 1'b0;
      forever begin
         @(posedge cyclk);
         #2;
         if (gen_if.code_load && !prev_load) load_log.push_back(gen_if.delay_code);
         prev_load = gen_if.code_load;
         if (done) done_cnt++;
         if (done && err) overlap_cnt++;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge cyclk);
   endtask

   task automatic kick(input logic [1:0] m, input int s, input int e, input int st, input int dw);
      load_log.delete();
      mode       = m;
      start_code = CW'(s);
      stop_code  = CW'(e);
      step       = CW'(st);
      dwell      = DW'(dw);
      start      = 1'b1;
      @(negedge cyclk);
      start      = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int i;
      bit seen;
      seen = 1'b0;
      for (i = 0; i < bound; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge cyclk);
      end
      check_val({tag, "_done"}, 32'(seen), 1);
      check_val({tag, "_busy_at_done"}, 32'(busy), 0);
   endtask

   task automatic wait_log(input string tag, input int n, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         if (load_log.size() >= n) break;
         @(negedge cyclk);
      end
      if (load_log.size() < n) check_val({tag, "_log_timeout"}, 32'(load_log.size()), 32'(n));
   endtask

   task automatic wait_load(input string tag, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         if (gen_if.code_load) break;
         @(negedge cyclk);
      end
      check_val({tag, "_load_seen"}, 32'(gen_if.code_load), 1);
   endtask

   task automatic check_log(input string tag, input int exp[$]);
      check_val({tag, "_count"}, 32'(load_log.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++) begin
         if (i < load_log.size()) check_val($sformatf("%s_code%0d", tag, i), 32'(load_log[i]), 32'(exp[i]));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_delay_code"}, 32'(gen_if.delay_code), 0);
      check_val({tag, "_code_load"}, 32'(gen_if.code_load), 0);
      check_val({tag, "_busy"}, 32'(busy), 0);
      check_val({tag, "_done"}, 32'(done), 0);
      check_val({tag, "_err"}, 32'(err), 0);
      check_val({tag, "_point_cnt"}, 32'(point_cnt), 0);
   endtask

   initial begin
      int lat;
      int hi;

      rst = 1'b0;
      locked = 1'b1;
      cyc(3);
      check_reset_outputs("rst");
      rst = 1'b1;
      cyc(4);

      // single up with latency check
      kick(2'b00, 10, 40, 10, 3);
      lat = 1;
      while (!gen_if.code_load && lat < 10) begin
         @(negedge cyclk);
         lat++;
      end
      check_val("start_latency", 32'(lat), 3);
      wait_done("up", 500);
      exp_done++;
      check_val("up_point_cnt", 32'(point_cnt), 4);
      check_log("up", '{10, 20, 30, 40});
      cyc(3);
      check_val("up_done_pulses", 32'(done_cnt), 32'(exp_done));

      // start with abort in idle: abort wins
      load_log.delete();
      start = 1'b1;
      abort = 1'b1;
      @(negedge cyclk);
      start = 1'b0;
      abort = 1'b0;
      check_val("start_abort_busy", 32'(busy), 0);
      cyc(4);
      check_val("start_abort_noload", 32'(load_log.size()), 0);

      // down with clamp, no wrap
      kick(2'b00, 250, 5, 100, 1);
      wait_done("down", 500);
      exp_done++;
      check_log("down", '{250, 150, 50, 5});

      // triangle then abort
      kick(2'b10, 0, 3, 1, 1);
      wait_log("tri", 9, 600);
      check_log("tri", '{0, 1, 2, 3, 2, 1, 0, 1, 2});
      abort = 1'b1;
      @(negedge cyclk);
      abort = 1'b0;
      check_val("tri_abort_busy", 32'(busy), 0);
      check_val("tri_abort_load", 32'(gen_if.code_load), 0);
      check_val("tri_abort_code_hold", 32'(gen_if.delay_code), 2);
      cyc(2);
      check_val("tri_abort_no_done", 32'(done_cnt), 32'(exp_done));

      // lock drop during dwell of code 20
      kick(2'b00, 10, 40, 10, 20);
      wait_log("lock", 2, 300);
      hi = 0;
      while (gen_if.code_load && hi < 50) begin
         @(negedge cyclk);
         hi++;
      end
      check_val("lock_pcnt_before", 32'(point_cnt), 2);
      locked = 1'b0;
      cyc(5);
      check_val("lock_pcnt_uncount", 32'(point_cnt), 1);
      check_val("lock_load_low", 32'(gen_if.code_load), 0);
      check_val("lock_busy", 32'(busy), 1);
      cyc(5);
      locked = 1'b1;
      wait_done("lock", 1000);
      exp_done++;
      check_val("lock_point_cnt", 32'(point_cnt), 4);
      check_log("lock", '{10, 20, 20, 30, 40});

      // continuous wrap; shadowed inputs and start-while-busy ignored
      kick(2'b01, 5, 7, 1, 1);
      start_code = 8'd100;
      stop_code  = 8'd200;
      step       = 8'd9;
      start      = 1'b1;
      @(negedge cyclk);
      start      = 1'b0;
      wait_log("cont", 5, 600);
      check_log("cont", '{5, 6, 7, 5, 6});
      check_val("cont_pcnt_after_wrap", 32'(point_cnt), 1);
      abort = 1'b1;
      @(negedge cyclk);
      abort = 1'b0;
      check_val("cont_abort_busy", 32'(busy), 0);

      // step 0 and dwell 0 act as 1; mode 11 is single
      kick(2'b11, 3, 6, 0, 0);
      wait_done("step0", 500);
      exp_done++;
      check_log("step0", '{3, 4, 5, 6});

      // ack timeout
      ack_en = 1'b0;
      kick(2'b00, 7, 9, 1, 1);
      wait_load("to", 10);
      hi = 0;
      while (gen_if.code_load && hi < 200) begin
         hi++;
         @(negedge cyclk);
      end
      check_val("to_load_cycles", 32'(hi), ACK_TO);
      check_val("to_err", 32'(err), 1);
      check_val("to_busy", 32'(busy), 0);
      cyc(2);
      check_val("to_no_done", 32'(done_cnt), 32'(exp_done));
      check_val("to_err_sticky", 32'(err), 1);

      // single point sweep, clears err
      ack_en = 1'b1;
      kick(2'b00, 50, 50, 3, 2);
      check_val("onept_err_clear", 32'(err), 0);
      wait_done("onept", 300);
      exp_done++;
      check_val("onept_point_cnt", 32'(point_cnt), 1);
      check_log("onept", '{50});

      // reset in the middle of WAIT_ACK
      ack_en = 1'b0;
      kick(2'b00, 1, 9, 1, 1);
      wait_load("midrst", 10);
      cyc(5);
      rst = 1'b0;
      @(negedge cyclk);
      check_reset_outputs("midrst");
      rst = 1'b1;
      ack_en = 1'b1;
      cyc(4);
      check_val("midrst_idle", 32'(busy), 0);

      check_val("done_err_overlap", 32'(overlap_cnt), 0);
      check_val("done_total", 32'(done_cnt), 32'(exp_done));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
